fifo_burst_reader: RTL

Read-side drain stage for the 33-entry async FIFO: runs in the read clock domain, watches the FIFO's `empty` and `gauge`, issues `ren` in bursts and presents popped words downstream on a valid/ready interface. A 2-entry output buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure. Reads start when a full burst is available, or when a partial fill has waited past a timeout. This keeps the FIFO drained without single-word dribbling.

---
 rtl/fifo_burst_reader_if.sv | 25 ++
 rtl/fifo_burst_reader.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the FIFO read port, the burst reader and the downstream consumer.
// The reader holds the master modport; the FIFO/consumer side holds the slave modport.
interface fifo_burst_reader_if #(
  parameter int unsigned WIDTH = 8
);
  logic             empty;
  logic [5:0]       gauge;
  logic [WIDTH-1:0] rdata;
  logic             ren;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic [5:0]       rd_count;

  modport master (
    input  empty, gauge, rdata, dready,
    output ren, dout, dvalid, busy, rd_count
  );

  modport slave (
    output empty, gauge, rdata, dready,
    input  ren, dout, dvalid, busy, rd_count
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side drain stage: pops the async FIFO in bursts (or after a partial-fill timeout) and
// presents words on valid/ready through a 2-entry buffer that hides the FIFO read latency.
module fifo_burst_reader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BURST   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 rclk,
  input logic                 rst,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned     TimerW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);
  localparam logic [5:0]      BurstLen = 6'(BURST);

  typedef enum logic {StIdle, StDrain} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [5:0]        rd_count_q, rd_count_d;
  logic              inflight_q;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0]  buf_q [2];
  logic [WIDTH-1:0]  buf_d [2];

  logic pop;
  logic room;
  logic ren;

  // The pop credit lets a read issue into a slot that is being vacated this very cycle.
  always_comb begin
    pop  = (buf_cnt_q != 2'd0) && bus.dready;
    room = (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
    ren  = (state_q == StDrain) && !bus.empty && room;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rd_count_d = rd_count_q;
    case (state_q)
      StIdle: begin
        if ((bus.gauge >= BurstLen) || (!bus.empty && (timer_q == TimerMax))) begin
          state_d = StDrain;
          timer_d = '0;
        end else if (bus.empty) begin
          timer_d = '0;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDrain: begin
        // Empty also covers the unexpected case of entering with nothing to read.
        if ((ren && ((rd_count_q + 6'd1) == BurstLen)) || bus.empty) begin
          state_d    = StIdle;
          rd_count_d = '0;
          timer_d    = '0;
        end else if (ren) begin
          rd_count_d = rd_count_q + 6'd1;
        end
      end
    endcase
  end

  always_comb begin
    buf_d[0]  = buf_q[0];
    buf_d[1]  = buf_q[1];
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    // Capture lands behind whatever survives the pop; room guarantees a free slot.
    if (inflight_q) begin
      buf_d[buf_cnt_d[0]] = bus.rdata;
      buf_cnt_d           = buf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_count_q <= rd_count_d;
      inflight_q <= ren;
      buf_cnt_q  <= buf_cnt_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

  assign bus.ren      = ren;
  assign bus.dout     = buf_q[0];
  assign bus.dvalid   = (buf_cnt_q != 2'd0);
  assign bus.busy     = (state_q == StDrain);
  assign bus.rd_count = rd_count_q;

endmodule
